// File: rtl/vga_plot_sink.sv
// Receiving end of the VGA plot bus: captures plots into a frame memory, offers
// pipelined readback, plot/drop statistics and a frame-idle detector.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RUN   | plots accepted into the frame memory
// ST_CLEAR | sweeping CLEAR_COLOUR over every pixel; plots are dropped
module vga_plot_sink #(
    parameter int         WIDTH        = 160,
    parameter int         HEIGHT       = 120,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000,
    parameter int         IDLE_CYCLES  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  vga_x,
    input  logic [6:0]  vga_y,
    input  logic [2:0]  vga_colour,
    input  logic        vga_plot,
    input  logic        start_clear,
    output logic        busy,
    input  logic        rd_req,
    input  logic [7:0]  rd_x,
    input  logic [6:0]  rd_y,
    output logic        rd_valid,
    output logic [2:0]  rd_data,
    output logic        rd_err,
    output logic [15:0] plot_count,
    output logic [15:0] drop_count,
    output logic [7:0]  last_x,
    output logic [6:0]  last_y,
    output logic        frame_idle
);

    localparam int DEPTH = WIDTH * HEIGHT;
    localparam int AW    = 15;
    localparam int IW    = $clog2(IDLE_CYCLES + 1);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [2:0] mem [DEPTH];

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic          busy_q, busy_d;
    logic [15:0]   plot_count_q, plot_count_d;
    logic [15:0]   drop_count_q, drop_count_d;
    logic [7:0]    last_x_q, last_x_d;
    logic [6:0]    last_y_q, last_y_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic          seen_plot_q, seen_plot_d;

    logic          rd_v1_q, rd_v1_d;
    logic          rd_err1_q, rd_err1_d;
    logic [2:0]    rd_mem_q;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_err_q, rd_err_d;
    logic [2:0]    rd_data_q, rd_data_d;

    logic          plot_in_range, plot_ok, plot_bad;
    logic          rd_in_range;
    logic [AW-1:0] plot_addr, rd_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [2:0]    wr_data;

    always_comb begin
        plot_in_range = (32'(vga_x) < WIDTH) && (32'(vga_y) < HEIGHT);
        plot_ok       = vga_plot && (state_q == ST_RUN) && plot_in_range;
        plot_bad      = vga_plot && !plot_ok;
        plot_addr     = plot_in_range ? AW'(32'(vga_y) * WIDTH + 32'(vga_x)) : '0;

        // Out-of-range read coordinates are steered to address 0 so the
        // memory is never indexed past its end; the result is masked later.
        rd_in_range   = (32'(rd_x) < WIDTH) && (32'(rd_y) < HEIGHT);
        rd_addr       = rd_in_range ? AW'(32'(rd_y) * WIDTH + 32'(rd_x)) : '0;

        wr_en   = rst_n && (plot_ok || (state_q == ST_CLEAR));
        wr_addr = (state_q == ST_CLEAR) ? clr_addr_q : plot_addr;
        wr_data = (state_q == ST_CLEAR) ? CLEAR_COLOUR : vga_colour;
    end

    // Read and write share one edge; the non-blocking read returns the old value.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_mem_q <= mem[rd_addr];
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        busy_d     = busy_q;
        case (state_q)
            ST_RUN: begin
                if (start_clear) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                    busy_d     = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (clr_addr_q == AW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b0;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        plot_count_d = plot_count_q;
        drop_count_d = drop_count_q;
        last_x_d     = last_x_q;
        last_y_d     = last_y_q;
        if (plot_ok) begin
            if (plot_count_q != 16'hFFFF) plot_count_d = plot_count_q + 16'd1;
            last_x_d = vga_x;
            last_y_d = vga_y;
        end
        if (plot_bad && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    // Idle timer only runs once a plot has landed since the last clear request.
    always_comb begin
        idle_cnt_d  = idle_cnt_q;
        seen_plot_d = seen_plot_q;
        if (vga_plot || start_clear) begin
            idle_cnt_d = '0;
        end else if (seen_plot_q && (idle_cnt_q != IW'(IDLE_CYCLES))) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
        if (start_clear) begin
            seen_plot_d = 1'b0;
        end else if (plot_ok) begin
            seen_plot_d = 1'b1;
        end
    end

    always_comb begin
        rd_v1_d    = rd_req;
        rd_err1_d  = rd_req && !rd_in_range;
        rd_valid_d = rd_v1_q;
        rd_err_d   = rd_v1_q && rd_err1_q;
        rd_data_d  = (rd_v1_q && !rd_err1_q) ? rd_mem_q : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            clr_addr_q   <= '0;
            busy_q       <= 1'b0;
            plot_count_q <= '0;
            drop_count_q <= '0;
            last_x_q     <= '0;
            last_y_q     <= '0;
            idle_cnt_q   <= '0;
            seen_plot_q  <= 1'b0;
            rd_v1_q      <= 1'b0;
            rd_err1_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_err_q     <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            busy_q       <= busy_d;
            plot_count_q <= plot_count_d;
            drop_count_q <= drop_count_d;
            last_x_q     <= last_x_d;
            last_y_q     <= last_y_d;
            idle_cnt_q   <= idle_cnt_d;
            seen_plot_q  <= seen_plot_d;
            rd_v1_q      <= rd_v1_d;
            rd_err1_q    <= rd_err1_d;
            rd_valid_q   <= rd_valid_d;
            rd_err_q     <= rd_err_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign busy       = busy_q;
    assign rd_valid   = rd_valid_q;
    assign rd_err     = rd_err_q;
    assign rd_data    = rd_data_q;
    assign plot_count = plot_count_q;
    assign drop_count = drop_count_q;
    assign last_x     = last_x_q;
    assign last_y     = last_y_q;
    assign frame_idle = (idle_cnt_q == IW'(IDLE_CYCLES));

endmodule

// File: tb/tb_vga_plot_sink.sv
// Bench for vga_plot_sink: directed scenarios plus randomized traffic, all
// checked every cycle against a frame/statistics model kept in the bench.
module tb_vga_plot_sink;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        start_clear;
    logic        busy;
    logic        rd_req;
    logic [7:0]  rd_x;
    logic [6:0]  rd_y;
    logic        rd_valid;
    logic [2:0]  rd_data;
    logic        rd_err;
    logic [15:0] plot_count;
    logic [15:0] drop_count;
    logic [7:0]  last_x;
    logic [6:0]  last_y;
    logic        frame_idle;

    always #5 clk = ~clk;

    vga_plot_sink dut (
        .clk(clk), .rst_n(rst_n),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .start_clear(start_clear), .busy(busy),
        .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
        .plot_count(plot_count), .drop_count(drop_count),
        .last_x(last_x), .last_y(last_y), .frame_idle(frame_idle)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        longint   due;
        bit       err;
        bit       known;
        bit [2:0] data;
    } rd_t;

    bit [2:0] m_mem   [19200];
    bit       m_known [19200];
    int       m_clear_left, m_plot_cnt, m_drop_cnt, m_last_x, m_last_y, m_idle;
    bit       m_seen;
    bit       model_on = 1'b0;
    longint   cyc = 0;
    rd_t      rq[$];

    task automatic model_step();
        bit  in_clear, ok;
        int  a;
        rd_t r;
        cyc++;
        if (!rst_n) begin
            m_clear_left = 0; m_plot_cnt = 0; m_drop_cnt = 0;
            m_last_x = 0; m_last_y = 0; m_idle = 0; m_seen = 1'b0;
            rq.delete();
            model_on = 1'b1;
        end else if (model_on) begin
            in_clear = (m_clear_left > 0);
            ok = vga_plot && !in_clear && (vga_x < 160) && (vga_y < 120);
            if (rd_req) begin
                r.due = cyc + 1;
                r.err = !((rd_x < 160) && (rd_y < 120));
                r.data = 3'b000;
                r.known = 1'b1;
                if (!r.err) begin
                    a = int'(rd_y) * 160 + int'(rd_x);
                    r.data = m_mem[a];
                    r.known = m_known[a];
                end
                rq.push_back(r);
            end
            if (ok) begin
                a = int'(vga_y) * 160 + int'(vga_x);
                m_mem[a] = vga_colour;
                m_known[a] = 1'b1;
                if (m_plot_cnt < 65535) m_plot_cnt++;
                m_last_x = int'(vga_x);
                m_last_y = int'(vga_y);
            end else if (vga_plot) begin
                if (m_drop_cnt < 65535) m_drop_cnt++;
            end
            if (in_clear) begin
                a = 19200 - m_clear_left;
                m_mem[a] = 3'b000;
                m_known[a] = 1'b1;
                m_clear_left--;
            end else if (start_clear) begin
                m_clear_left = 19200;
            end
            if (vga_plot || start_clear) m_idle = 0;
            else if (m_seen && m_idle < 64) m_idle++;
            if (start_clear) m_seen = 1'b0;
            else if (ok) m_seen = 1'b1;
        end
    endtask

    task automatic compare_step();
        bit  exp_v;
        rd_t r;
        if (!model_on) return;
        chk("busy", int'(busy), int'(m_clear_left > 0));
        exp_v = (rq.size() > 0) && (rq[0].due == cyc);
        chk("rd_valid", int'(rd_valid), int'(exp_v));
        if (exp_v) begin
            r = rq.pop_front();
            chk("rd_err", int'(rd_err), int'(r.err));
            if (r.known) chk("rd_data", int'(rd_data), int'(r.data));
        end
        chk("plot_count", int'(plot_count), m_plot_cnt);
        chk("drop_count", int'(drop_count), m_drop_cnt);
        chk("last_x", int'(last_x), m_last_x);
        chk("last_y", int'(last_y), m_last_y);
        chk("frame_idle", int'(frame_idle), int'(m_idle == 64));
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        compare_step();
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic plot1(input int x, input int y, input int c);
        vga_plot = 1'b1; vga_x = 8'(x); vga_y = 7'(y); vga_colour = 3'(c);
        tick();
        vga_plot = 1'b0;
    endtask

    task automatic read_chk(input string name, input int x, input int y,
                            input int e_err, input int e_data);
        rd_req = 1'b1; rd_x = 8'(x); rd_y = 7'(y);
        tick();
        rd_req = 1'b0;
        tick();
        chk({name, "_valid"}, int'(rd_valid), 1);
        chk({name, "_err"}, int'(rd_err), e_err);
        chk({name, "_data"}, int'(rd_data), e_data);
    endtask

    initial begin
        int n;
        int d0;
        int gap;
        rst_n = 1'b0; vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0;
        start_clear = 1'b0; rd_req = 1'b0; rd_x = '0; rd_y = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("reset_busy", int'(busy), 0);
        chk("reset_plot_count", int'(plot_count), 0);
        chk("reset_frame_idle", int'(frame_idle), 0);

        // full clear
        start_clear = 1'b1;
        tick();
        start_clear = 1'b0;
        chk("clear_busy_on", int'(busy), 1);
        n = 0;
        while (busy === 1'b1 && n < 25000) begin
            n++;
            tick();
        end
        chk("clear_length", n, 19200);
        read_chk("rd_0_0", 0, 0, 0, 0);
        read_chk("rd_159_119", 159, 119, 0, 0);
        read_chk("rd_80_60", 80, 60, 0, 0);

        // single accepted plot
        plot1(82, 20, 2);
        chk("plot1_count", int'(plot_count), 1);
        chk("plot1_last_x", int'(last_x), 82);
        chk("plot1_last_y", int'(last_y), 20);
        read_chk("rd_82_20", 82, 20, 0, 2);

        // out-of-range plots and read
        plot1(160, 5, 7);
        plot1(5, 120, 7);
        chk("drop_two", int'(drop_count), 2);
        chk("drop_plot_unch", int'(plot_count), 1);
        read_chk("rd_160_5", 160, 5, 1, 0);

        // read-before-write collision
        vga_plot = 1'b1; vga_x = 8'd10; vga_y = 7'd10; vga_colour = 3'b001;
        tick();
        vga_colour = 3'b100;
        rd_req = 1'b1; rd_x = 8'd10; rd_y = 7'd10;
        tick();
        vga_plot = 1'b0;
        tick();
        rd_req = 1'b0;
        chk("rbw_old_valid", int'(rd_valid), 1);
        chk("rbw_old_data", int'(rd_data), 1);
        tick();
        chk("rbw_new_valid", int'(rd_valid), 1);
        chk("rbw_new_data", int'(rd_data), 4);

        // idle detector
        for (int i = 0; i < 5; i++) begin
            vga_plot = 1'b1; vga_x = 8'(20 + i); vga_y = 7'd30; vga_colour = 3'b011;
            tick();
        end
        vga_plot = 1'b0;
        n = 0;
        while (frame_idle !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("idle_delay", n, 64);
        plot1(0, 0, 5);
        chk("idle_drop", int'(frame_idle), 0);

        // clear interrupted by reset
        start_clear = 1'b1;
        tick();
        start_clear = 1'b0;
        repeat (999) tick();
        d0 = int'(drop_count);
        plot1(1, 1, 7);
        plot1(1, 1, 7);
        chk("clr_drop", int'(drop_count), d0 + 2);
        chk("clr_busy", int'(busy), 1);
        read_chk("rd_clr_1_1", 1, 1, 0, 0);
        repeat (5000 - 1004) tick();
        chk("pre_reset_busy", int'(busy), 1);
        rst_n = 1'b0;
        tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_plot_count", int'(plot_count), 0);
        chk("rst_drop_count", int'(drop_count), 0);
        chk("rst_last_x", int'(last_x), 0);
        rst_n = 1'b1;
        plot1(1, 1, 6);
        chk("post_rst_plot", int'(plot_count), 1);
        read_chk("rd_post_rst", 1, 1, 0, 6);

        // randomized traffic against the model
        gap = 0;
        for (int i = 0; i < 4000; i++) begin
            if (gap == 0 && $urandom_range(0, 399) == 0) gap = $urandom_range(60, 90);
            if (gap > 0) begin
                gap--;
                vga_plot = 1'b0;
            end else begin
                vga_plot = ($urandom_range(0, 99) < 40);
            end
            vga_x = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 175)) : 8'($urandom_range(0, 7));
            vga_y = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 3));
            vga_colour = 3'($urandom_range(0, 7));
            rd_req = ($urandom_range(0, 1) == 1);
            rd_x = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 175)) : 8'($urandom_range(0, 7));
            rd_y = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 3));
            tick();
        end
        vga_plot = 1'b0;
        rd_req = 1'b0;
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_plot_sink.md
Name: vga_plot_sink

Overview:
- Receiving end of the VGA plot interface (x, y, colour, plot) driven by the fill/circle drawing engines.
- Captures every accepted plot into an internal WIDTH x HEIGHT x 3-bit frame memory.
- Provides a random-access readback port, plot/drop statistics, and a frame-idle detector.
- Serves as a synthesizable stand-in for the VGA adapter in regression, and as an on-chip frame checker.

Parameters:
- WIDTH, 160, horizontal resolution in pixels.
- HEIGHT, 120, vertical resolution in pixels.
- CLEAR_COLOUR, 3'b000, colour written to every pixel by a clear sweep.
- IDLE_CYCLES, 64, consecutive cycles with vga_plot low, after activity, that raise frame_idle.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- vga_x  in  8  plot x coordinate.
- vga_y  in  7  plot y coordinate.
- vga_colour  in  3  plot colour.
- vga_plot  in  1  plot strobe; one pixel per cycle while high.
- start_clear  in  1  single-cycle request to sweep the frame to CLEAR_COLOUR.
- busy  out  1  high while the clear sweep runs.
- rd_req  in  1  readback request.
- rd_x  in  8  readback x coordinate.
- rd_y  in  7  readback y coordinate.
- rd_valid  out  1  one-cycle pulse; rd_data is valid this cycle.
- rd_data  out  3  readback colour.
- rd_err  out  1  qualifies rd_valid; requested coordinate was out of range.
- plot_count  out  16  accepted plots, saturating at 16'hFFFF.
- drop_count  out  16  rejected plots, saturating at 16'hFFFF.
- last_x  out  8  x coordinate of the most recent accepted plot.
- last_y  out  7  y coordinate of the most recent accepted plot.
- frame_idle  out  1  level; asserted when the idle timeout expires.

Behaviour:
- Address mapping: addr = y*WIDTH + x, 15 bits; for WIDTH=160, computed as (y<<7)+(y<<5)+x. Memory has WIDTH*HEIGHT entries, one write port and one read port.
- Reset values (rst_n low at a clock edge): busy=0, rd_valid=0, rd_data=0, rd_err=0, plot_count=0, drop_count=0, last_x=0, last_y=0, frame_idle=0, idle counter=0, seen_plot=0, FSM=RUN.
- Memory contents are NOT reset; a clear is required before readback results are meaningful.
- FSM states:
  - RUN: accepts plots. start_clear moves to CLEAR with sweep address 0 and sets busy=1 on the next cycle.
  - CLEAR: writes CLEAR_COLOUR to one address per cycle, 0 through WIDTH*HEIGHT-1, taking exactly 19200 cycles. After the final write it returns to RUN and drops busy. start_clear is ignored while in CLEAR.
- Plot acceptance: vga_plot=1 in RUN with x<WIDTH and y<HEIGHT.
  - The memory is written at that edge.
  - plot_count increments and last_x/last_y update.
  - seen_plot is set.
- Plot rejection: vga_plot=1 with x or y out of range, or any plot while in CLEAR.
  - drop_count increments and the memory is untouched.
- Both counters saturate and never wrap.
- If start_clear and an in-range plot occur in the same cycle in RUN, the plot is accepted, then the clear begins.
- Readback:
  - rd_req is accepted in any state. rd_valid pulses exactly 2 cycles after the rd_req cycle.
  - Back-to-back requests are fully pipelined, one per cycle.
  - For an out-of-range coordinate, rd_err=1 and rd_data=0.
  - Otherwise rd_err=0 and rd_data is the memory content.
  - A read and a write to the same address at the same edge returns the OLD value (read-before-write). A read in the following cycle returns the new value.
- Idle detector:
  - Counter resets to 0 on any cycle with vga_plot=1, and on start_clear.
  - Otherwise, if seen_plot=1, it increments, saturating at IDLE_CYCLES.
  - frame_idle=1 while the counter equals IDLE_CYCLES.
  - frame_idle clears on the next vga_plot=1 or start_clear.
  - start_clear also clears seen_plot.
- Reset mid-clear: the FSM returns to RUN and busy=0 on the reset edge. Memory is left partially cleared.

Test Plan:
- Reset, then pulse start_clear: busy=1 for exactly 19200 cycles. Reads of (0,0), (159,119) and (80,60) then return 3'b000 with rd_err=0.
- After clear, plot (82,20) colour 3'b010 for one cycle:
  - plot_count=1, last_x=82, last_y=20.
  - rd_req (82,20) gives rd_valid 2 cycles later with rd_data=3'b010.
- Plot (160,5) and (5,120), each colour 3'b111: drop_count=2, plot_count unchanged. rd_req (160,5) returns rd_err=1, rd_data=0.
- Plot (10,10)=3'b001, then in the next cycle plot (10,10)=3'b100 and rd_req (10,10) in the same cycle: rd_data=3'b001. A repeat read the next cycle returns 3'b100.
- Plot 5 pixels, then hold vga_plot low: frame_idle rises exactly 64 cycles after the last plot cycle. One further plot drops it next cycle.
- Start a clear, issue plots at (1,1) during busy, assert rst_n low at sweep cycle 5000:
  - During clear, plots raise drop_count and leave memory untouched.
  - On the reset edge, busy=0 and all counters are 0.
  - A subsequent plot is accepted normally.
